// File: rtl/smi_pkg.sv
// Shared SMI definitions: EOFC width, end-of-frame test and arbiter FSM states.
package smi_pkg;

    localparam int unsigned SMI_EOFC_WIDTH = 8;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_FORWARD
    } arbState_e;

    function automatic logic smiIsLastFlit(input logic [SMI_EOFC_WIDTH-1:0] eofc);
        return eofc != '0;
    endfunction

endpackage

// File: rtl/smi_rr_select.sv
// Combinational round-robin pick: first eligible port at index >= rrPtr, wrapping over NumPorts.
module smi_rr_select #(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned PortIdxWidth = 2
) (
    input  logic [NumPorts-1:0]     eligible,
    input  logic [PortIdxWidth-1:0] rrPtr,
    output logic [PortIdxWidth-1:0] grantIdx,
    output logic                    anyValid
);

    int                      idx;
    logic [PortIdxWidth-1:0] idxSel;

    // Scan from the farthest offset down so the nearest eligible port wins.
    always_comb begin
        grantIdx = '0;
        idx      = 0;
        idxSel   = '0;
        anyValid = |eligible;
        for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
            idx    = (int'(rrPtr) + k) % int'(NumPorts);
            idxSel = PortIdxWidth'(idx);
            if (eligible[idxSel]) begin
                grantIdx = idxSel;
            end
        end
    end

endmodule

// File: rtl/smi_read_req_arbiter.sv
// Frame-level round-robin arbiter sharing one SMI read-request link between NumPorts requesters,
// with per-port outstanding-read credit counters and a single registered output stage.
module smi_read_req_arbiter
    import smi_pkg::*;
#(
    parameter int unsigned NumPorts       = 4,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned PortIdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned CountWidth    = $clog2(MaxOutstanding + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NumPorts-1:0]                reqReady,
    input  logic [SMI_EOFC_WIDTH*NumPorts-1:0] reqEofc,
    input  logic [DataWidth*NumPorts-1:0]      reqData,
    output logic [NumPorts-1:0]                reqStop,
    output logic                               outReady,
    output logic [SMI_EOFC_WIDTH-1:0]          outEofc,
    output logic [DataWidth-1:0]               outData,
    input  logic                               outStop,
    input  logic [NumPorts-1:0]                respDone,
    output logic [PortIdxWidth-1:0]            grantPort,
    output logic                               busy
);

    arbState_e                            stateQ, stateD;
    logic [PortIdxWidth-1:0]              grantD, rrPtrQ, rrPtrD, selIdx;
    logic                                 anyValid;
    logic [NumPorts-1:0]                  eligible;
    logic [NumPorts-1:0][CountWidth-1:0]  cntQ, cntD;
    logic [NumPorts-1:0]                  incVec, decVec;
    logic [SMI_EOFC_WIDTH-1:0]            curEofc;
    logic [DataWidth-1:0]                 curData;
    logic                                 accept, frameEnd;

    assign curEofc  = reqEofc[int'(grantPort)*SMI_EOFC_WIDTH +: SMI_EOFC_WIDTH];
    assign curData  = reqData[int'(grantPort)*DataWidth +: DataWidth];
    assign frameEnd = accept & smiIsLastFlit(curEofc);
    assign busy     = (stateQ == ARB_FORWARD);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            eligible[i] = reqReady[i] & (cntQ[i] < CountWidth'(MaxOutstanding));
        end
    end

    smi_rr_select #(
        .NumPorts     (NumPorts),
        .PortIdxWidth (PortIdxWidth)
    ) u_select (
        .eligible (eligible),
        .rrPtr    (rrPtrQ),
        .grantIdx (selIdx),
        .anyValid (anyValid)
    );

    always_comb begin
        stateD  = stateQ;
        grantD  = grantPort;
        rrPtrD  = rrPtrQ;
        reqStop = '1;
        accept  = 1'b0;
        unique case (stateQ)
            ARB_IDLE: begin
                if (anyValid) begin
                    grantD = selIdx;
                    stateD = ARB_FORWARD;
                end
            end
            ARB_FORWARD: begin
                // A full output register that cannot drain blocks the granted port.
                reqStop[grantPort] = outReady & outStop;
                accept             = reqReady[grantPort] & ~(outReady & outStop);
                if (accept && smiIsLastFlit(curEofc)) begin
                    rrPtrD = (int'(grantPort) == int'(NumPorts) - 1) ?
                             '0 : grantPort + PortIdxWidth'(1);
                    stateD = ARB_IDLE;
                end
            end
            default: stateD = ARB_IDLE;
        endcase
    end

    // Simultaneous frame-end and respDone on one port cancel; respDone at zero is dropped.
    always_comb begin
        cntD   = cntQ;
        incVec = '0;
        decVec = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            incVec[i] = frameEnd && (grantPort == PortIdxWidth'(i));
            decVec[i] = respDone[i] && (cntQ[i] != '0);
            if (incVec[i] && !decVec[i]) begin
                cntD[i] = cntQ[i] + CountWidth'(1);
            end else if (decVec[i] && !incVec[i]) begin
                cntD[i] = cntQ[i] - CountWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= ARB_IDLE;
            grantPort <= '0;
            rrPtrQ    <= '0;
            cntQ      <= '0;
        end else begin
            stateQ    <= stateD;
            grantPort <= grantD;
            rrPtrQ    <= rrPtrD;
            cntQ      <= cntD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outReady <= 1'b0;
            outEofc  <= '0;
            outData  <= '0;
        end else if (accept) begin
            outReady <= 1'b1;
            outEofc  <= curEofc;
            outData  <= curData;
        end else if (outReady && !outStop) begin
            outReady <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smi_read_req_arbiter.sv
// Directed and randomised checks of smi_read_req_arbiter: arbitration order, credits, stalls, reset.
module tb_smi_read_req_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int MO = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   reqReady;
    logic [8*NP-1:0] reqEofc;
    logic [DW*NP-1:0] reqData;
    logic [NP-1:0]   reqStop;
    logic            outReady;
    logic [7:0]      outEofc;
    logic [DW-1:0]   outData;
    logic            outStop;
    logic [NP-1:0]   respDone;
    logic [1:0]      grantPort;
    logic            busy;

    int total = 0;
    int bad = 0;
    int cycleCount = 0;

    logic [63:0] srcData [NP][$];
    logic [7:0]  srcEofc [NP][$];
    int          hold [NP];
    logic [63:0] capData [$];
    logic [7:0]  capEofc [$];
    int          capCyc [$];
    logic [63:0] expData [NP][$];
    logic [7:0]  expEofc [NP][$];

    smi_read_req_arbiter #(
        .NumPorts       (NP),
        .DataWidth      (DW),
        .MaxOutstanding (MO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqReady  (reqReady),
        .reqEofc   (reqEofc),
        .reqData   (reqData),
        .reqStop   (reqStop),
        .outReady  (outReady),
        .outEofc   (outEofc),
        .outData   (outData),
        .outStop   (outStop),
        .respDone  (respDone),
        .grantPort (grantPort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mkData(input int port, input int frame, input int idx);
        return {8'(port), 16'(frame), 8'(idx), 32'hA5A50000 ^ 32'(frame * 7 + idx)};
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (srcData[p].size() > 0 && hold[p] == 0) begin
                reqReady[p]          = 1'b1;
                reqData[p*DW +: DW]  = srcData[p][0];
                reqEofc[p*8 +: 8]    = srcEofc[p][0];
            end else begin
                reqReady[p]          = 1'b0;
                reqData[p*DW +: DW]  = '0;
                reqEofc[p*8 +: 8]    = '0;
            end
        end
    endtask

    task automatic loadFrame(input int port, input int frame, input int len, input logic [7:0] eofc);
        for (int i = 0; i < len; i++) begin
            srcData[port].push_back(mkData(port, frame, i));
            srcEofc[port].push_back((i == len - 1) ? eofc : 8'h00);
        end
    endtask

    // Called #1 after a rising edge; samples handshakes just before the next edge.
    task automatic tick();
        logic [NP-1:0] acc;
        logic          oacc;
        logic [63:0]   od;
        logic [7:0]    oe;
        #3;
        acc  = reqReady & ~reqStop;
        oacc = outReady & ~outStop;
        od   = outData;
        oe   = outEofc;
        @(posedge clk);
        #1;
        cycleCount++;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                void'(srcData[p].pop_front());
                void'(srcEofc[p].pop_front());
            end
            if (hold[p] > 0) hold[p]--;
        end
        if (oacc) begin
            capData.push_back(od);
            capEofc.push_back(oe);
            capCyc.push_back(cycleCount);
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        outStop  = 1'b0;
        respDone = '0;
        for (int p = 0; p < NP; p++) begin
            srcData[p].delete();
            srcEofc[p].delete();
            expData[p].delete();
            expEofc[p].delete();
            hold[p] = 0;
        end
        capData.delete();
        capEofc.delete();
        capCyc.delete();
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        do_reset();
        rst_n = 1'b0;
        #1;
        total++; if (reqStop !== 4'hf) begin bad++; $display("FAIL reset_reqStop: got %0h expected f", reqStop); end
        total++; if (outReady !== 1'b0) begin bad++; $display("FAIL reset_outReady: got %0b expected 0", outReady); end
        total++; if (outEofc !== 8'h00) begin bad++; $display("FAIL reset_outEofc: got %0h expected 0", outEofc); end
        total++; if (outData !== 64'h0) begin bad++; $display("FAIL reset_outData: got %0h expected 0", outData); end
        total++; if (grantPort !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d expected 0", grantPort); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        do_reset();
        tick();
        total++; if (busy !== 1'b0 || reqStop !== 4'hf) begin
            bad++; $display("FAIL idle_after_reset: busy=%0b reqStop=%0h expected 0/f", busy, reqStop);
        end
    endtask

    task automatic test_two_frames();
        int c0;
        logic [63:0] ed [6];
        int          ec [6];
        do_reset();
        c0 = cycleCount;
        loadFrame(0, 0, 3, 8'h03);
        loadFrame(2, 0, 3, 8'h03);
        drive();
        tick();
        total++; if (grantPort !== 2'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL tf_grant0: grant=%0d busy=%0b expected 0/1", grantPort, busy);
        end
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tf_gap: busy=%0b expected 0", busy); end
        tick();
        total++; if (grantPort !== 2'd2 || busy !== 1'b1) begin
            bad++; $display("FAIL tf_grant2: grant=%0d busy=%0b expected 2/1", grantPort, busy);
        end
        repeat (5) tick();
        for (int i = 0; i < 6; i++) begin
            ed[i] = mkData((i < 3) ? 0 : 2, 0, i % 3);
            ec[i] = c0 + ((i < 3) ? 3 + i : 4 + i);
        end
        total++;
        if (capData.size() != 6) begin
            bad++; $display("FAIL tf_count: got %0d flits expected 6", capData.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (capData[i] !== ed[i] || capCyc[i] != ec[i]) begin
                    bad++; $display("FAIL tf_flit%0d: got %0h@%0d expected %0h@%0d",
                                    i, capData[i], capCyc[i], ed[i], ec[i]);
                end
                total++; if (capEofc[i] !== ((i % 3 == 2) ? 8'h03 : 8'h00)) begin
                    bad++; $display("FAIL tf_eofc%0d: got %0h", i, capEofc[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int c0;
        do_reset();
        c0 = cycleCount;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < NP; p++) loadFrame(p, f, 1, 8'h01);
        drive();
        repeat (18) tick();
        total++;
        if (capData.size() != 8) begin
            bad++; $display("FAIL rr_count: got %0d frames expected 8", capData.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (capData[i] !== mkData(i % 4, i / 4, 0) || capCyc[i] != c0 + 3 + 2 * i) begin
                    bad++; $display("FAIL rr_frame%0d: got %0h@%0d expected %0h@%0d", i, capData[i],
                                    capCyc[i], mkData(i % 4, i / 4, 0), c0 + 3 + 2 * i);
                end
            end
        end
    endtask

    task automatic test_credit_block();
        do_reset();
        for (int f = 0; f < 3; f++) loadFrame(1, f, 1, 8'h01);
        drive();
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (reqStop[1] !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL cb_blocked%0d: reqStop1=%0b busy=%0b expected 1/0", i, reqStop[1], busy);
            end
        end
        total++; if (dut.cntQ[1] !== 2'd2) begin bad++; $display("FAIL cb_cnt_full: got %0d expected 2", dut.cntQ[1]); end
        total++; if (capData.size() != 2) begin bad++; $display("FAIL cb_frames: got %0d expected 2", capData.size()); end
        respDone = 4'b0010;
        tick();
        respDone = '0;
        total++; if (dut.cntQ[1] !== 2'd1) begin bad++; $display("FAIL cb_cnt_dec: got %0d expected 1", dut.cntQ[1]); end
        tick();
        total++; if (busy !== 1'b1 || grantPort !== 2'd1) begin
            bad++; $display("FAIL cb_regrant: busy=%0b grant=%0d expected 1/1", busy, grantPort);
        end
        repeat (2) tick();
        total++; if (capData.size() != 3 || capData[capData.size()-1] !== mkData(1, 2, 0)) begin
            bad++; $display("FAIL cb_third: got %0d frames expected 3 ending %0h", capData.size(), mkData(1, 2, 0));
        end
    endtask

    task automatic test_counter_edge();
        do_reset();
        loadFrame(3, 0, 1, 8'h01);
        loadFrame(3, 1, 1, 8'h01);
        drive();
        repeat (3) tick();
        total++; if (dut.cntQ[3] !== 2'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL ce_pre: cnt3=%0d busy=%0b expected 1/1", dut.cntQ[3], busy);
        end
        respDone = 4'b1000;
        tick();
        respDone = '0;
        total++; if (dut.cntQ[3] !== 2'd1) begin bad++; $display("FAIL ce_cancel: cnt3=%0d expected 1", dut.cntQ[3]); end
        respDone = 4'b0001;
        tick();
        respDone = '0;
        total++; if (dut.cntQ[0] !== 2'd0) begin bad++; $display("FAIL ce_underflow: cnt0=%0d expected 0", dut.cntQ[0]); end
        repeat (2) tick();
        total++; if (capData.size() != 2) begin bad++; $display("FAIL ce_frames: got %0d expected 2", capData.size()); end
    endtask

    task automatic test_midframe_hold();
        int c0;
        int ec [4];
        logic [63:0] ed [4];
        do_reset();
        c0 = cycleCount;
        loadFrame(0, 0, 3, 8'h01);
        loadFrame(1, 0, 1, 8'h01);
        drive();
        repeat (2) tick();
        hold[0] = 5;
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (grantPort !== 2'd0 || busy !== 1'b1 || reqStop[1] !== 1'b1) begin
                bad++; $display("FAIL mh_hold%0d: grant=%0d busy=%0b stop1=%0b expected 0/1/1",
                                i, grantPort, busy, reqStop[1]);
            end
        end
        repeat (6) tick();
        ed[0] = mkData(0, 0, 0); ed[1] = mkData(0, 0, 1); ed[2] = mkData(0, 0, 2); ed[3] = mkData(1, 0, 0);
        ec[0] = c0 + 3; ec[1] = c0 + 9; ec[2] = c0 + 10; ec[3] = c0 + 12;
        total++;
        if (capData.size() != 4) begin
            bad++; $display("FAIL mh_count: got %0d flits expected 4", capData.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (capData[i] !== ed[i] || capCyc[i] != ec[i]) begin
                    bad++; $display("FAIL mh_flit%0d: got %0h@%0d expected %0h@%0d",
                                    i, capData[i], capCyc[i], ed[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int remaining = 0;
        int pend [3];
        int port;
        int len;
        logic [7:0] le;
        logic [63:0] d;
        logic [7:0] e;
        int budget = 0;
        do_reset();
        for (int p = 0; p < 3; p++) pend[p] = 0;
        for (int f = 0; f < 1000; f++) begin
            port = $urandom_range(0, 2);
            len  = $urandom_range(1, 8);
            le   = 8'($urandom_range(1, 255));
            loadFrame(port, f, len, le);
            for (int i = 0; i < len; i++) begin
                expData[port].push_back(mkData(port, f, i));
                expEofc[port].push_back((i == len - 1) ? le : 8'h00);
            end
            remaining += len;
        end
        drive();
        while (remaining > 0 && budget < 60000) begin
            budget++;
            outStop = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < 3; p++) begin
                if (pend[p] > 0 && $urandom_range(0, 1) == 1) begin
                    respDone[p] = 1'b1;
                    pend[p]--;
                end
            end
            tick();
            respDone = '0;
            while (capData.size() > 0) begin
                d = capData.pop_front();
                e = capEofc.pop_front();
                void'(capCyc.pop_front());
                port = int'(d[63:56]);
                remaining--;
                total++;
                if (port > 2 || expData[port].size() == 0) begin
                    bad++; $display("FAIL rnd_unexpected: got %0h from port %0d", d, port);
                end else if (d !== expData[port][0] || e !== expEofc[port][0]) begin
                    bad++; $display("FAIL rnd_order: got %0h/%0h expected %0h/%0h",
                                    d, e, expData[port][0], expEofc[port][0]);
                    void'(expData[port].pop_front());
                    void'(expEofc[port].pop_front());
                end else begin
                    void'(expData[port].pop_front());
                    void'(expEofc[port].pop_front());
                    if (e != 8'h00) pend[port]++;
                end
            end
        end
        outStop = 1'b0;
        total++; if (remaining != 0) begin
            bad++; $display("FAIL rnd_timeout: got %0d flits outstanding expected 0", remaining);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        loadFrame(0, 0, 4, 8'h01);
        drive();
        repeat (2) tick();
        total++; if (outReady !== 1'b1 || reqStop[0] !== 1'b0) begin
            bad++; $display("FAIL ar_pre: outReady=%0b stop0=%0b expected 1/0", outReady, reqStop[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (outReady !== 1'b0) begin bad++; $display("FAIL ar_outReady: got %0b expected 0", outReady); end
        total++; if (reqStop !== 4'hf) begin bad++; $display("FAIL ar_reqStop: got %0h expected f", reqStop); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %0b expected 0", busy); end
        do_reset();
    endtask

    initial begin
        rst_n    = 1'b0;
        outStop  = 1'b0;
        respDone = '0;
        reqReady = '0;
        reqEofc  = '0;
        reqData  = '0;
        test_reset();
        test_two_frames();
        test_round_robin();
        test_credit_block();
        test_counter_edge();
        test_midframe_hold();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
